event_blinker: RTL

EVENT_BLINKER -- requirements
Module: event_blinker

---
 rtl/event_blinker_if.sv | 19 +
 rtl/event_blinker.sv | 125 ++++++++++++
 2 files changed

// File: rtl/event_blinker_if.sv
// Event-blinker signal bundle: event strobe in, blink level and queue status out.
// The ovf line exists only when EVENT_BLINKER_OVF_EN is defined.
interface event_blinker_if #(
    parameter int PEND_W = 3
);
    logic              D;
    logic              O;
    logic              busy;
    logic [PEND_W-1:0] pending;
`ifdef EVENT_BLINKER_OVF_EN
    logic              ovf;

    modport master (output D, input O, input busy, input pending, input ovf);
    modport slave  (input D, output O, output busy, output pending, output ovf);
`else
    modport master (output D, input O, input busy, input pending);
    modport slave  (input D, output O, output busy, output pending);
`endif
endinterface

// File: rtl/event_blinker.sv
// Turns each event strobe into one ON_CYCLES-long pulse, queueing bursts and
// enforcing a GAP_CYCLES low gap; sticky overflow flag under EVENT_BLINKER_OVF_EN.
module event_blinker #(
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PEND_W     = 3
) (
    input  logic           clk,
    input  logic           reset,
    event_blinker_if.slave bus
);

    localparam int TMR_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    logic [PEND_W-1:0] pending;
    logic              consume;
    logic              have_event;
    logic              o_q;
    logic              busy_q;

    // An event taken straight from D cancels its own increment, so the queue
    // only moves when exactly one of (arrival, consume) happens.
    function automatic logic [PEND_W-1:0] pend_sat(input logic [PEND_W-1:0] p,
                                                   input logic d,
                                                   input logic c);
        logic [PEND_W-1:0] r;
        r = p;
        if (d && !c) begin
            if (p != PEND_MAX) r = p + 1'b1;
        end else if (!d && c) begin
            r = p - 1'b1;
        end
        return r;
    endfunction

    assign have_event = bus.D || (pending != '0);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                if (have_event) begin
                    consume   = 1'b1;
                    state_nxt = ON;
                    timer_nxt = ON_LOAD;
                end
            end
            ON: begin
                if (timer == '0) begin
                    state_nxt = GAP;
                    timer_nxt = GAP_LOAD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (have_event) begin
                    consume   = 1'b1;
                    state_nxt = ON;
                    timer_nxt = ON_LOAD;
                end else begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // O and busy are registered copies of the next state, so D never reaches O combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            pending <= '0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            pending <= pend_sat(pending, bus.D, consume);
            o_q     <= (state_nxt == ON);
            busy_q  <= (state_nxt != IDLE);
        end
    end

    assign bus.O       = o_q;
    assign bus.busy    = busy_q;
    assign bus.pending = pending;

`ifdef EVENT_BLINKER_OVF_EN
    logic drop;
    logic ovf_q;

    assign drop = bus.D && !consume && (pending == PEND_MAX);

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
